// File: rtl/systolic_skew_buffer_if.sv
// Stream bundle for the skew buffer: word input handshake plus the per-step skewed output.
interface systolic_skew_buffer_if #(
  parameter int LANES  = 10,
  parameter int DATA_W = 8
) ();
  logic                    in_valid_i;
  logic                    in_last_i;
  logic                    in_ready_o;
  logic [LANES*DATA_W-1:0] word_i;
  logic [LANES*DATA_W-1:0] skew_o;
  logic [LANES-1:0]        lane_valid_o;
  logic                    out_valid_o;
  logic                    out_last_o;

  modport slave (
    input  in_valid_i, in_last_i, word_i,
    output in_ready_o, skew_o, lane_valid_o, out_valid_o, out_last_o
  );

  modport master (
    output in_valid_i, in_last_i, word_i,
    input  in_ready_o, skew_o, lane_valid_o, out_valid_o, out_last_o
  );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Skew/deskew buffer feeding the systolic array edge: lane k is delayed k (or LANES-1-k) steps,
// with a zero-injected drain after the last word of each stream.
module systolic_skew_buffer #(
  parameter int LANES  = 10,
  parameter int DATA_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic                  dir_i,
  systolic_skew_buffer_if.slave bus,
  output logic                  busy_o
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dir_q;
  logic                    accept;
  logic                    step;
  logic                    eff_dir;
  logic                    inj_valid;
  logic [LANES*DATA_W-1:0] inj_data;

  assign bus.in_ready_o = en_i && !flush_i && (state_q != DRAIN);
  assign accept         = bus.in_ready_o && bus.in_valid_i;
  assign step           = accept || (en_i && !flush_i && (state_q == DRAIN));
  assign inj_valid      = accept;
  assign inj_data       = accept ? bus.word_i : '0;
  // The opening accept of a stream already needs the new direction for its zero-delay lanes.
  assign eff_dir        = (state_q == IDLE) ? dir_i : dir_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && (state_q == IDLE)) dir_q <= dir_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (!bus.in_last_i) begin
            state_d = RUN;
          end else if (LANES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(LANES - 1);
          end
        end
      end
      DRAIN: begin
        if (step) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid_o = step;
    bus.out_last_o  = (step && (state_q == DRAIN) && (cnt_q == CNT_W'(1))) ||
                      ((LANES == 1) && accept && bus.in_last_i);
    busy_o          = (state_q != IDLE);
  end

  // Stage s holds the slot injected s+1 steps ago; the chain only moves on a step.
  if (LANES > 1) begin : g_chain
    logic [LANES*DATA_W-1:0] data_q [LANES-1];
    logic [LANES-2:0]        valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s < LANES - 1; s++) data_q[s] <= '0;
        valid_q <= '0;
      end else if (flush_i) begin
        for (int s = 0; s < LANES - 1; s++) data_q[s] <= '0;
        valid_q <= '0;
      end else if (step) begin
        for (int s = LANES - 2; s > 0; s--) begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
        end
        data_q[0]  <= inj_data;
        valid_q[0] <= inj_valid;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int D_SKEW   = k;
    localparam int D_DESKEW = LANES - 1 - k;

    logic [DATA_W-1:0] skew_data, deskew_data;
    logic              skew_vld, deskew_vld;

    if (D_SKEW == 0) begin : g_skew_direct
      assign skew_data = inj_data[k*DATA_W +: DATA_W];
      assign skew_vld  = inj_valid;
    end else begin : g_skew_tap
      assign skew_data = g_chain.data_q[D_SKEW-1][k*DATA_W +: DATA_W];
      assign skew_vld  = g_chain.valid_q[D_SKEW-1];
    end

    if (D_DESKEW == 0) begin : g_deskew_direct
      assign deskew_data = inj_data[k*DATA_W +: DATA_W];
      assign deskew_vld  = inj_valid;
    end else begin : g_deskew_tap
      assign deskew_data = g_chain.data_q[D_DESKEW-1][k*DATA_W +: DATA_W];
      assign deskew_vld  = g_chain.valid_q[D_DESKEW-1];
    end

    assign bus.skew_o[k*DATA_W +: DATA_W] = eff_dir ? deskew_data : skew_data;
    assign bus.lane_valid_o[k]            = eff_dir ? deskew_vld  : skew_vld;
  end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Bench for systolic_skew_buffer: directed streams against fixed tables plus random traffic
// checked against a history-based reference model.
module tb_systolic_skew_buffer;

  localparam int L  = 4;
  localparam int W  = 8;
  localparam int BW = L * W;

  logic clk_i = 1'b0;
  logic rst_ni, en_i, flush_i, dir_i, busy_o, busy1;

  systolic_skew_buffer_if #(.LANES(L), .DATA_W(W)) bus  ();
  systolic_skew_buffer_if #(.LANES(1), .DATA_W(W)) bus1 ();

  systolic_skew_buffer #(.LANES(L), .DATA_W(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i), .dir_i(dir_i),
    .bus(bus), .busy_o(busy_o)
  );

  systolic_skew_buffer #(.LANES(1), .DATA_W(W)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i), .dir_i(dir_i),
    .bus(bus1), .busy_o(busy1)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: slots injected on past steps, newest first.
  logic [BW-1:0] hist_d[$];
  bit            hist_v[$];
  bit            m_active, m_drain, m_dir;
  int            m_left;

  logic [BW-1:0] words   [3];
  logic [BW-1:0] tbl_skew[2][6];
  logic [L-1:0]  tbl_lv  [2][6];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist_d.delete();
    hist_v.delete();
    m_active = 0;
    m_drain  = 0;
    m_dir    = 0;
    m_left   = 0;
  endtask

  task automatic check_model();
    logic ready, acc, stp, ed, last_e;
    logic [BW-1:0] es;
    logic [L-1:0]  ev;
    int d;
    ready  = en_i && !flush_i && !m_drain;
    acc    = ready && bus.in_valid_i;
    stp    = acc || (en_i && !flush_i && m_drain);
    ed     = m_active ? m_dir : dir_i;
    last_e = stp && m_drain && (m_left == 1);
    es = '0;
    ev = '0;
    for (int k = 0; k < L; k++) begin
      d = ed ? (L - 1 - k) : k;
      if (d == 0) begin
        if (acc) begin
          es[k*W +: W] = bus.word_i[k*W +: W];
          ev[k]        = 1'b1;
        end
      end else if (d <= hist_d.size()) begin
        es[k*W +: W] = hist_d[d-1][k*W +: W];
        ev[k]        = hist_v[d-1];
      end
    end
    check_output("in_ready",   bus.in_ready_o,   ready);
    check_output("out_valid",  bus.out_valid_o,  stp);
    check_output("out_last",   bus.out_last_o,   last_e);
    check_output("busy",       busy_o,           m_active);
    check_output("skew",       bus.skew_o,       es);
    check_output("lane_valid", bus.lane_valid_o, ev);

    if (flush_i) begin
      model_clear();
    end else if (stp) begin
      hist_d.push_front(acc ? bus.word_i : '0);
      hist_v.push_front(acc);
      if (hist_d.size() > L - 1) begin
        void'(hist_d.pop_back());
        void'(hist_v.pop_back());
      end
      if (acc) begin
        if (!m_active) m_dir = dir_i;
        m_active = 1;
        if (bus.in_last_i) begin
          m_drain = 1;
          m_left  = L - 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_drain  = 0;
          m_active = 0;
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic flush, input logic dir,
                                input logic valid, input logic last, input logic [BW-1:0] word);
    @(negedge clk_i);
    en_i           = en;
    flush_i        = flush;
    dir_i          = dir;
    bus.in_valid_i = valid;
    bus.in_last_i  = last;
    bus.word_i     = word;
    #1;
    check_model();
  endtask

  task automatic check_step(input bit dir, input int s);
    check_output("tbl_skew", bus.skew_o,       tbl_skew[dir][s]);
    check_output("tbl_lv",   bus.lane_valid_o, tbl_lv[dir][s]);
    check_output("tbl_last", bus.out_last_o,   (s == 5));
  endtask

  task automatic run_stream(input bit dir, input int gap, input int en_hold, input bit toggle_dir);
    int s = 0;
    for (int w = 0; w < 3; w++) begin
      if (w == 2) begin
        for (int g = 0; g < gap; g++) begin
          apply_stimulus(1, 0, dir, 0, 0, '0);
          check_output("gap_ovalid", bus.out_valid_o, 0);
        end
      end
      apply_stimulus(1, 0, (toggle_dir && w > 0) ? ~dir : dir, 1, (w == 2), words[w]);
      check_step(dir, s);
      s++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        for (int h = 0; h < en_hold; h++) begin
          apply_stimulus(0, 0, dir, 0, 0, '0);
          check_output("hold_ready",  bus.in_ready_o,  0);
          check_output("hold_ovalid", bus.out_valid_o, 0);
        end
      end
      apply_stimulus(1, 0, toggle_dir ? ~dir : dir, 0, 0, '0);
      check_step(dir, s);
      s++;
    end
    apply_stimulus(1, 0, 0, 0, 0, '0);
    check_output("end_busy",  busy_o,         0);
    check_output("end_ready", bus.in_ready_o, 1);
  endtask

  initial begin
    words       = '{32'h13121110, 32'h23222120, 32'h33323130};
    tbl_skew[0] = '{32'h00000010, 32'h00001120, 32'h00122130, 32'h13223100, 32'h23320000, 32'h33000000};
    tbl_skew[1] = '{32'h13000000, 32'h23120000, 32'h33221100, 32'h00322110, 32'h00003120, 32'h00000030};
    tbl_lv[0]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    tbl_lv[1]   = '{4'b1000, 4'b1100, 4'b1110, 4'b0111, 4'b0011, 4'b0001};

    model_clear();
    rst_ni = 1'b0; en_i = 1'b1; flush_i = 1'b0; dir_i = 1'b0;
    bus.in_valid_i  = 1'b0; bus.in_last_i  = 1'b0; bus.word_i  = '0;
    bus1.in_valid_i = 1'b0; bus1.in_last_i = 1'b0; bus1.word_i = '0;
    #2;
    check_output("rst_ready",  bus.in_ready_o,   1);
    check_output("rst_busy",   busy_o,           0);
    check_output("rst_skew",   bus.skew_o,       0);
    check_output("rst_lv",     bus.lane_valid_o, 0);
    check_output("rst_ovalid", bus.out_valid_o,  0);
    check_output("rst_olast",  bus.out_last_o,   0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] directed streams");
    run_stream(0, 0, 0, 0);
    run_stream(1, 0, 0, 1);
    run_stream(0, 3, 0, 0);
    run_stream(0, 0, 2, 0);
    run_stream(1, 2, 2, 0);

    $display("[TB] flush during drain");
    for (int w = 0; w < 3; w++) apply_stimulus(1, 0, 0, 1, (w == 2), words[w]);
    apply_stimulus(1, 0, 0, 0, 0, '0);
    apply_stimulus(1, 1, 0, 0, 0, '0);
    check_output("flush_ready",  bus.in_ready_o,  0);
    check_output("flush_ovalid", bus.out_valid_o, 0);
    apply_stimulus(1, 0, 0, 0, 0, '0);
    check_output("post_flush_busy",  busy_o,           0);
    check_output("post_flush_lv",    bus.lane_valid_o, 0);
    check_output("post_flush_skew",  bus.skew_o,       0);
    check_output("post_flush_ready", bus.in_ready_o,   1);

    $display("[TB] async reset mid-run");
    apply_stimulus(1, 0, 1, 1, 0, words[0]);
    apply_stimulus(1, 0, 1, 1, 0, words[1]);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    #1;
    check_output("pre_rst_busy", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("async_busy", busy_o,           0);
    check_output("async_skew", bus.skew_o,       0);
    check_output("async_lv",   bus.lane_valid_o, 0);
    model_clear();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    $display("[TB] single lane");
    @(negedge clk_i);
    en_i = 1'b1; flush_i = 1'b0;
    bus1.in_valid_i = 1'b1; bus1.in_last_i = 1'b1; bus1.word_i = 8'hA5;
    #1;
    check_output("l1_skew",   bus1.skew_o,       8'hA5);
    check_output("l1_lv",     bus1.lane_valid_o, 1);
    check_output("l1_ovalid", bus1.out_valid_o,  1);
    check_output("l1_olast",  bus1.out_last_o,   1);
    check_output("l1_busy",   busy1,             0);
    @(negedge clk_i);
    bus1.in_valid_i = 1'b0;
    #1;
    check_output("l1_idle_busy",   busy1,            0);
    check_output("l1_idle_ovalid", bus1.out_valid_o, 0);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 4) == 0, $urandom);
    end
    for (int c = 0; c < 8; c++) apply_stimulus(1, 0, 0, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_skew_buffer.md
Name: systolic_skew_buffer

Overview:
- Parametrised skew/deskew buffer between the operand buffers and the systolic array edge.
- Lane k of an N-lane word is delayed by k steps (skew mode) or N-1-k steps (deskew mode, for realigning array outputs).
- Adds a valid/ready/last stream handshake, automatic zero-injected drain after the last word, per-lane valid tags, a stall enable and a synchronous flush.

Parameters:
- LANES, 10, number of lanes per word (>=1).
- DATA_W, 8, bits per lane.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- en_i  input  1  global enable; low freezes all state.
- flush_i  input  1  synchronous clear; priority over everything except rst_ni.
- dir_i  input  1  0 = skew (lane k delay k), 1 = deskew (lane k delay LANES-1-k).
- in_valid_i  input  1  input word valid.
- in_last_i  input  1  marks final word of a stream.
- in_ready_o  output  1  block accepts a word this cycle.
- word_i  input  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
- skew_o  output  LANES*DATA_W  delayed lanes, same packing.
- lane_valid_o  output  LANES  bit k set when skew_o lane k carries real data.
- out_valid_o  output  1  a step occurred this cycle; skew_o/lane_valid_o meaningful.
- out_last_o  output  1  final step of the stream (last word's most-delayed lane present).
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset (async) and flush_i: state=IDLE, drain counter=0, all delay registers and valid tags = 0, latched dir = 0. Outputs: in_ready_o=en_i (flush cycle: 0), out_valid_o=0, out_last_o=0, busy_o=0, skew_o=0, lane_valid_o=0.
- Step = en_i && !flush_i && ((in_valid_i && in_ready_o) || state==DRAIN). Delay chain advances only on a step; it holds otherwise, preserving alignment across input gaps.
- in_ready_o = en_i && !flush_i && state != DRAIN.
- Injected slot: on an accept, the chain input is word_i with valid=1. During DRAIN it is all zeros with valid=0.
- Lane output for delay d:
  - d=0: the injected slot combinationally, masked to 0 (data and valid) when no step.
  - d>0: chain stage d-1 tap.
- Storage is triangular; any equivalent structure is acceptable.
- out_valid_o = step (combinational). lane_valid_o and skew_o are driven every cycle from the taps; they are only meaningful when out_valid_o=1.
- Direction: dir_i is latched on the accept that leaves IDLE. The latched value governs all taps until return to IDLE; dir_i changes mid-stream are ignored.
- FSM:
  - IDLE: accept without last -> RUN. Accept with last -> DRAIN with counter=LANES-1; if LANES==1, stays IDLE and out_last_o=1 that cycle.
  - RUN: accept with last -> DRAIN, counter=LANES-1. Accept without last or no accept -> RUN.
  - DRAIN: each step decrements counter. The step with counter==1 asserts out_last_o and goes to IDLE.
- en_i low: no step, counter and state frozen, out_valid_o=0, in_ready_o=0.
- Latency: lane with delay d of word n appears on the d-th step after its accept step (same cycle for d=0).
- Drain length: exactly LANES-1 steps after the last accept; total steps per stream = words + LANES-1.
- The next stream may be accepted in the cycle immediately after out_last_o.

Test Plan:
(LANES=4, DATA_W=8. W0 lanes3..0 = 13,12,11,10; W1 = 23..20; W2 = 33..30, hex.)
- Skew, dir=0, W0,W1,W2(last) back-to-back -> skew_o/lane_valid_o per step:
  - {00,00,00,10}/0001
  - {00,00,11,20}/0011
  - {00,12,21,30}/0111
  - {13,22,31,00}/1110
  - {23,32,00,00}/1100
  - {33,00,00,00}/1000 with out_last_o=1
  - then busy_o=0, in_ready_o=1.
- Deskew, dir=1, same stream -> first step {13,00,00,00}/1000 … final step {00,00,00,30}/0001 with out_last_o=1. dir_i toggled mid-stream has no effect.
- Gap: in_valid_i low 3 cycles between W1 and W2 -> out_valid_o=0 those cycles. Step outputs are identical to the back-to-back case.
- en_i low 2 cycles during DRAIN -> in_ready_o=0, out_valid_o=0, counter held. Drain completes 2 cycles later with identical data.
- flush_i during DRAIN -> next cycle busy_o=0, lane_valid_o=0, skew_o=0, in_ready_o=1. rst_ni pulsed asynchronously mid-RUN clears the same outputs immediately, without waiting for a clock edge.
- LANES=1: single word A5 with last -> skew_o=A5, out_valid_o=1, out_last_o=1 in the same cycle; state stays IDLE.
